// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_deserializer
//  Description : Serial-to-parallel capture stage. Samples one serial bit per
//                qualified clock (sin_valid), assembles WIDTH-bit words and
//                hands each completed word off through a valid/ready holding
//                register. A sticky overrun flag records any completed word
//                that had to be dropped because the holding register was busy.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous reset, active-high
//                sin        - serial data bit
//                sin_valid  - sin is sampled on this edge when high
//                pout       - assembled word (holding register)
//                pout_valid - pout holds an unconsumed word
//                pout_ready - consumer accepts pout when pout_valid is high
//                bit_cnt    - bits currently held in the shift register
//                overrun    - sticky dropped-word flag
//                clr_ovr    - synchronous clear of overrun
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sin,
    input  logic                       sin_valid,
    output logic [WIDTH-1:0]           pout,
    output logic                       pout_valid,
    input  logic                       pout_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overrun,
    input  logic                       clr_ovr
);

    localparam int                 C_CNT_W = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_next_shift;
    logic             w_complete;
    logic             w_free;

    // Shift register contents with this edge's bit included; on a completing
    // edge this is exactly the finished word.
    always_comb begin
        w_next_shift = r_shift;
        if (MSB_FIRST) begin
            w_next_shift = {r_shift[WIDTH-2:0], sin};
        end else begin
            w_next_shift = {sin, r_shift[WIDTH-1:1]};
        end
    end

    assign w_complete = sin_valid && (bit_cnt == C_LAST);
    // Holding register can take a new word if empty or being drained this edge.
    assign w_free     = !pout_valid || pout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            bit_cnt    <= '0;
            pout       <= '0;
            pout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sin_valid) begin
                r_shift <= w_next_shift;
                bit_cnt <= w_complete ? '0 : bit_cnt + C_ONE;
            end

            if (w_complete && w_free) begin
                pout       <= w_next_shift;
                pout_valid <= 1'b1;
            end else if (pout_valid && pout_ready) begin
                pout_valid <= 1'b0;
            end

            // A fresh drop takes priority over a simultaneous clear.
            if (w_complete && !w_free) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_deserializer
//  Description : Self-checking bench for serial_deserializer. Two instances
//                (MSB-first and LSB-first) share one input stream; a queue
//                based reference model predicts both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         pout_ready;
    logic         clr_ovr;

    logic [W-1:0] pout_m, pout_l;
    logic         pv_m, pv_l;
    logic [3:0]   cnt_m, cnt_l;
    logic         ovr_m, ovr_l;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int           q_bits[$];
    logic [W-1:0] m_pout_m = '0;
    logic [W-1:0] m_pout_l = '0;
    logic         m_valid  = 1'b0;
    logic         m_ovr    = 1'b0;

    always #5 clk = ~clk;

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready),
        .bit_cnt(cnt_m), .overrun(ovr_m), .clr_ovr(clr_ovr)
    );

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid),
        .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready),
        .bit_cnt(cnt_l), .overrun(ovr_l), .clr_ovr(clr_ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one clock edge: bits collect in a queue, and a
    // full queue becomes a word by positional weighting.
    task automatic model_edge(input logic r, input logic s, input logic sv,
                              input logic rdy, input logic clr);
        logic         complete;
        logic         free;
        logic [W-1:0] wm, wl;
        complete = 1'b0;
        wm = '0;
        wl = '0;
        if (r) begin
            q_bits.delete();
            m_pout_m = '0;
            m_pout_l = '0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            free = !m_valid || rdy;
            if (sv) begin
                q_bits.push_back(int'(s));
                if (q_bits.size() == W) begin
                    complete = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wm = wm | (W'(q_bits[i]) << (W - 1 - i));
                        wl = wl | (W'(q_bits[i]) << i);
                    end
                    q_bits.delete();
                end
            end
            if (complete && free) begin
                m_pout_m = wm;
                m_pout_l = wl;
                m_valid  = 1'b1;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (complete && !free) m_ovr = 1'b1;
            else if (clr)          m_ovr = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("pout_msb",  32'(pout_m), 32'(m_pout_m));
        check("pout_lsb",  32'(pout_l), 32'(m_pout_l));
        check("valid_msb", 32'(pv_m),   32'(m_valid));
        check("valid_lsb", 32'(pv_l),   32'(m_valid));
        check("cnt_msb",   32'(cnt_m),  32'(q_bits.size()));
        check("cnt_lsb",   32'(cnt_l),  32'(q_bits.size()));
        check("ovr_msb",   32'(ovr_m),  32'(m_ovr));
        check("ovr_lsb",   32'(ovr_l),  32'(m_ovr));
    endtask

    // Drive inputs, take one edge, update the model, sample 1 time unit later.
    task automatic step(input logic r, input logic s, input logic sv,
                        input logic rdy, input logic clr);
        rst = r; sin = s; sin_valid = sv; pout_ready = rdy; clr_ovr = clr;
        @(posedge clk);
        model_edge(r, s, sv, rdy, clr);
        #1;
        compare_all();
    endtask

    // Send a byte MSB first; ready is asserted only on the last bit if requested.
    task automatic send_byte(input logic [7:0] v, input logic rdy_last);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, v[i], 1'b1, (i == 0) ? rdy_last : 1'b0, 1'b0);
        end
    endtask

    task automatic accept();
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] v;
        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; pout_ready = 1'b0; clr_ovr = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_pout",  32'(pout_m), 32'h0);
        check("rst_valid", 32'(pv_m),   32'h0);
        check("rst_ovr",   32'(ovr_m),  32'h0);

        // Word 1,0,1,0,0,1,0,1 with ready low
        send_byte(8'hA5, 1'b0);
        check("t1_pout_msb", 32'(pout_m), 32'hA5);
        check("t1_pout_lsb", 32'(pout_l), 32'hA5);
        check("t1_valid",    32'(pv_m),   32'h1);
        check("t1_cnt",      32'(cnt_m),  32'h0);

        // 1,1,0,0,0,0,0,0 -> LSB-first instance sees 8'h03
        accept();
        check("t2_drained", 32'(pv_m), 32'h0);
        send_byte(8'hC0, 1'b0);
        check("t2_pout_lsb", 32'(pout_l), 32'h03);
        check("t2_pout_msb", 32'(pout_m), 32'hC0);

        // Overrun: 3C pending, then FF arrives with ready low
        accept();
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("t3_ovr",  32'(ovr_m),  32'h1);
        check("t3_pout", 32'(pout_m), 32'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t3_clr",  32'(ovr_m),  32'h0);

        // Accept on the completing edge while 3C pending
        send_byte(8'h5A, 1'b1);
        check("t4_pout",  32'(pout_m), 32'h5A);
        check("t4_valid", 32'(pv_m),   32'h1);
        check("t4_ovr",   32'(ovr_m),  32'h0);

        // Qualified bits interleaved with unqualified junk
        accept();
        v = 8'h96;
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, v[i], 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end
        check("t5_pout", 32'(pout_m), 32'h96);

        // Reset mid-word discards the partial word and pending state
        send_byte(8'h00, 1'b0);  // forces an overrun with 96 pending
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_valid", 32'(pv_m),  32'h0);
        check("t6_ovr",   32'(ovr_m), 32'h0);
        check("t6_cnt",   32'(cnt_m), 32'h0);
        send_byte(8'hC3, 1'b0);
        check("t6_pout",  32'(pout_m), 32'hC3);
        check("t6_lsb",   32'(pout_l), 32'hC3);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
